// File: rtl/stream_enable_ctrl.sv
// Receive-side stream gate: synchronises sensor-reset / stream-enable, passes only whole
// frames from the sensor to the frame buffer, and turns a sensor reset into a timed flush.
module stream_enable_ctrl #(
  parameter int DATA_WD      = 8,
  parameter int FLUSH_CYCLES = 16,
  parameter int FRAME_CNT_WD = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_reset_sensor,
  input  logic                    i_stream_enable,
  input  logic                    i_fval,
  input  logic                    i_lval,
  input  logic [DATA_WD-1:0]      i_pix_data,
  output logic                    o_fval,
  output logic                    o_lval,
  output logic [DATA_WD-1:0]      o_pix_data,
  output logic                    o_stream_active,
  output logic                    o_flush,
  output logic                    o_frame_done,
  output logic [FRAME_CNT_WD-1:0] o_frame_cnt,
  output logic [2:0]              dbg_state
);

  localparam int FC_WD = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_WD-1:0] FC_LAST = FC_WD'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    ACTIVE     = 3'd2,
    STOP_PEND  = 3'd3,
    FLUSH      = 3'd4
  } state_t;

  state_t           state;
  logic             rst_meta, rst_s;
  logic             en_meta, en_s;
  logic             fval_d;
  logic [FC_WD-1:0] flush_cnt;
  logic             frame_start, frame_end, gate;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_s    <= 1'b0;
      en_meta  <= 1'b0;
      en_s     <= 1'b0;
    end else begin
      rst_meta <= i_reset_sensor;
      rst_s    <= rst_meta;
      en_meta  <= i_stream_enable;
      en_s     <= en_meta;
    end
  end

  assign frame_start = i_fval & ~fval_d;
  assign frame_end   = ~i_fval & fval_d;
  assign dbg_state   = state;

  // The frame-start cycle out of WAIT_FRAME is gated in so the first line is never clipped.
  always_comb begin
    gate = 1'b0;
    if (!rst_s) begin
      gate = (state == ACTIVE) || (state == STOP_PEND) ||
             ((state == WAIT_FRAME) && en_s && frame_start);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      fval_d          <= 1'b0;
      flush_cnt       <= '0;
      o_fval          <= 1'b0;
      o_lval          <= 1'b0;
      o_pix_data      <= '0;
      o_stream_active <= 1'b0;
      o_flush         <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_cnt     <= '0;
    end else begin
      fval_d       <= i_fval;
      o_fval       <= i_fval & gate;
      o_lval       <= i_lval & i_fval & gate;
      o_pix_data   <= (gate & i_fval & i_lval) ? i_pix_data : '0;
      o_frame_done <= 1'b0;

      if (rst_s) begin
        // Sensor reset wins over everything; the counter reloads while it is held.
        state           <= FLUSH;
        flush_cnt       <= FC_LAST;
        o_flush         <= 1'b1;
        o_stream_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (en_s) state <= WAIT_FRAME;
          end
          WAIT_FRAME: begin
            if (!en_s) begin
              state <= IDLE;
            end else if (frame_start) begin
              state           <= ACTIVE;
              o_stream_active <= 1'b1;
            end
          end
          ACTIVE: begin
            if (frame_end) begin
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + 1'b1;
              if (!en_s) begin
                state           <= IDLE;
                o_stream_active <= 1'b0;
              end
            end else if (!en_s) begin
              state <= STOP_PEND;
            end
          end
          STOP_PEND: begin
            if (frame_end) begin
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + 1'b1;
              if (en_s) begin
                state <= ACTIVE;
              end else begin
                state           <= IDLE;
                o_stream_active <= 1'b0;
              end
            end else if (en_s) begin
              state <= ACTIVE;
            end
          end
          FLUSH: begin
            if (flush_cnt == '0) begin
              o_flush <= 1'b0;
              state   <= en_s ? WAIT_FRAME : IDLE;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          default: begin
            state           <= IDLE;
            o_flush         <= 1'b0;
            o_stream_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_enable_ctrl.sv
// Directed bench for stream_enable_ctrl: frame gating, enable/disable on frame
// boundaries, sensor-reset flush, async reset and frame-counter wrap.
module tb_stream_enable_ctrl;
  localparam int DW = 8;
  localparam int FC = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_reset_sensor = 1'b0;
  logic          i_stream_enable = 1'b0;
  logic          i_fval = 1'b0;
  logic          i_lval = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic          o_fval, o_lval, o_stream_active, o_flush, o_frame_done;
  logic [DW-1:0] o_pix_data;
  logic [CW-1:0] o_frame_cnt;
  logic [2:0]    dbg_state;

  stream_enable_ctrl #(.DATA_WD(DW), .FLUSH_CYCLES(FC), .FRAME_CNT_WD(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_reset_sensor(i_reset_sensor),
    .i_stream_enable(i_stream_enable), .i_fval(i_fval), .i_lval(i_lval),
    .i_pix_data(i_pix_data), .o_fval(o_fval), .o_lval(o_lval), .o_pix_data(o_pix_data),
    .o_stream_active(o_stream_active), .o_flush(o_flush), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  logic [DW+1:0] exp_q[$];
  int            done_tally = 0;
  int            flush_tally = 0;
  logic          prev_fval = 1'b0;
  logic          last_done_active = 1'b0;
  logic          rst_cur = 1'b0;
  logic          en_cur = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: drive inputs after the edge, sample at the falling edge, score the
  // output against the prediction made for the previous cycle's inputs.
  task automatic cycle(input logic f, input logic l, input logic [DW-1:0] d,
                       input logic pass, input logic rs, input logic en);
    logic [DW+1:0] e;
    @(posedge clk);
    #1;
    i_fval = f; i_lval = l; i_pix_data = d;
    i_reset_sensor = rs; i_stream_enable = en;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gated_out", 32'({o_fval, o_lval, o_pix_data}), 32'(e));
    end
    e = pass ? {f, f & l, (f & l) ? d : DW'(0)} : '0;
    exp_q.push_back(e);
    if (o_frame_done) begin
      done_tally++;
      last_done_active = o_stream_active;
      check("done_on_fval_fall", 32'({prev_fval, o_fval}), 32'(2'b10));
    end
    if (o_flush) flush_tally++;
    prev_fval = o_fval;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, rst_cur, en_cur);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs",
             32'({o_fval, o_lval, o_pix_data, o_stream_active, o_flush, o_frame_done,
                  o_frame_cnt, dbg_state}), 32'd0);
    exp_q.delete();
    prev_fval = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  // Frame: one fval-only cycle, then per line `pix` pixels plus 2 blank cycles.
  // Cycle idx is passed when pass_lo <= idx < pass_hi.
  task automatic frame(input int lines, input int pix, input int pass_lo, input int pass_hi,
                       input int en_at, input int rst_at, input int areset_at,
                       input logic [DW-1:0] base);
    int n;
    int k;
    logic l;
    logic [DW-1:0] d;
    n = 1 + lines * (pix + 2);
    for (int idx = 0; idx < n; idx++) begin
      l = 1'b0;
      d = '0;
      if (idx > 0) begin
        k = (idx - 1) % (pix + 2);
        l = (k < pix);
      end
      if (l) d = base + DW'(idx);
      if (idx == en_at) en_cur = ~en_cur;
      if (idx == rst_at) rst_cur = 1'b1;
      if (idx == rst_at + 5) rst_cur = 1'b0;
      cycle(1'b1, l, d, (idx >= pass_lo) && (idx < pass_hi), rst_cur, en_cur);
      if (idx == areset_at) async_reset();
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({o_fval, o_lval, o_pix_data, o_stream_active, o_flush, o_frame_done,
               o_frame_cnt, dbg_state}), 32'd0);
    reset_n = 1'b1;
    en_cur = 1'b1;
    idle(6);

    // three full 4x8 frames pass through with 1-cycle latency
    for (int i = 0; i < 3; i++) begin
      frame(4, 8, 0, 1000, -1, -1, -1, DW'(8'h10 * (i + 1)));
      idle(4);
    end
    check("t1_done_tally", 32'(done_tally), 32'd3);
    check("t1_frame_cnt", 32'(o_frame_cnt), 32'd3);
    check("t1_active_at_done", 32'(last_done_active), 32'd1);
    check("t1_state_active", 32'(dbg_state), 32'd2);

    // enable dropped in line 2: whole frame still passes, then stream stops
    frame(4, 8, 0, 1000, 12, -1, -1, 8'h50);
    idle(4);
    check("t3_done_tally", 32'(done_tally), 32'd4);
    check("t3_frame_cnt", 32'(o_frame_cnt), 32'd4);
    check("t3_active_fell_at_done", 32'(last_done_active), 32'd0);
    check("t3_state_idle", 32'(dbg_state), 32'd0);
    check("t3_stream_active", 32'(o_stream_active), 32'd0);

    // enable raised mid-frame: partial frame blocked, next frame passes
    frame(4, 8, 0, 0, 3, -1, -1, 8'h60);
    idle(4);
    check("t2_no_partial_done", 32'(done_tally), 32'd4);
    check("t2_state_wait", 32'(dbg_state), 32'd1);
    frame(4, 8, 0, 1000, -1, -1, -1, 8'h70);
    idle(4);
    check("t2_done_tally", 32'(done_tally), 32'd5);
    check("t2_frame_cnt", 32'(o_frame_cnt), 32'd5);

    // sensor reset for 5 cycles mid-frame: truncated, flush, resume on next frame
    flush_tally = 0;
    frame(4, 8, 0, 14, -1, 12, -1, 8'h80);
    idle(4);
    check("t4_no_truncated_done", 32'(done_tally), 32'd5);
    check("t4_flush_len", 32'(flush_tally), 32'd20);
    check("t4_flush_low", 32'(o_flush), 32'd0);
    check("t4_state_wait", 32'(dbg_state), 32'd1);
    check("t4_cnt_kept", 32'(o_frame_cnt), 32'd5);
    frame(4, 8, 0, 1000, -1, -1, -1, 8'h90);
    idle(4);
    check("t4_resume_done", 32'(done_tally), 32'd6);
    check("t4_resume_cnt", 32'(o_frame_cnt), 32'd6);

    // async reset mid-frame in ACTIVE, then 17 frames wrap the 4-bit counter to 1
    frame(4, 8, 0, 10, -1, -1, 9, 8'hA0);
    idle(4);
    check("t5_state_wait", 32'(dbg_state), 32'd1);
    check("t5_cnt_cleared", 32'(o_frame_cnt), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      frame(2, 2, 0, 1000, -1, -1, -1, DW'(i * 3));
      idle(3);
      check("wrap_cnt", 32'(o_frame_cnt), 32'(i % 16));
    end
    check("final_done_tally", 32'(done_tally), 32'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
